// File: rtl/intr_src_ctrl_pkg.sv
// Shared constants for the interrupt source conditioner: register map,
// filter defaults and a small edge-detect helper.
package intr_src_ctrl_pkg;

    localparam int NUM_SRC      = 4;
    localparam int CNT_W        = 4;
    localparam int FILT_LEN_DEF = 3;

    typedef enum logic [1:0] {
        REG_ENA  = 2'd0,
        REG_MODE = 2'd1,
        REG_PEND = 2'd2,
        REG_RAW  = 2'd3
    } reg_addr_e;

    function automatic logic [NUM_SRC-1:0] rise_det(input logic [NUM_SRC-1:0] cur,
                                                    input logic [NUM_SRC-1:0] prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/intr_src_ctrl_if.sv
// CPU I/O port bus seen by the interrupt source conditioner.
interface intr_src_ctrl_if;
    import intr_src_ctrl_pkg::*;

    logic       io_sel;
    logic [1:0] io_addr;
    logic       io_wr;
    logic       io_rd;
    logic [7:0] io_wdata;
    logic [7:0] io_rdata;

    modport master (
        output io_sel, io_addr, io_wr, io_rd, io_wdata,
        input  io_rdata
    );

    modport slave (
        input  io_sel, io_addr, io_wr, io_rd, io_wdata,
        output io_rdata
    );

endinterface

// File: rtl/intr_filt.sv
// One interrupt source: 2-flop synchronizer followed by a glitch filter that
// flips the accepted level after FILT_LEN consecutive disagreeing samples.
module intr_filt
    import intr_src_ctrl_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic src,
    output logic sync_lvl,
    output logic filt_lvl
);

    localparam logic [CNT_W-1:0] FILT_TGT = CNT_W'(FILT_LEN);

    logic             sync1_r;
    logic             sync2_r;
    logic             filt_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             filt_nxt_s;

    // Filter decision: agreement clears the run, a full run flips the level.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        filt_nxt_s = filt_r;
        if (sync2_r == filt_r) begin
            cnt_nxt_s  = {CNT_W{1'b0}};
            filt_nxt_s = filt_r;
        end else if ((cnt_r + 4'd1) == FILT_TGT) begin
            cnt_nxt_s  = {CNT_W{1'b0}};
            filt_nxt_s = ~filt_r;
        end else begin
            cnt_nxt_s  = cnt_r + 4'd1;
            filt_nxt_s = filt_r;
        end
    end

    // Synchronizer, run counter and accepted level.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            filt_r  <= 1'b0;
        end else begin
            sync1_r <= src;
            sync2_r <= sync1_r;
            cnt_r   <= cnt_nxt_s;
            filt_r  <= filt_nxt_s;
        end
    end

    assign sync_lvl = sync2_r;
    assign filt_lvl = filt_r;

endmodule

// File: rtl/intr_src_ctrl.sv
// Interrupt source conditioner: filtered sources, level/edge request shaping,
// sticky pending bits and a CPU-visible register file (ENA, MODE, PEND, RAW).
module intr_src_ctrl
    import intr_src_ctrl_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic               clock,
    input  logic               reset,
    intr_src_ctrl_if.slave     bus,
    input  logic [NUM_SRC-1:0] src_in,
    output logic [NUM_SRC-1:0] intr_req,
    output logic [NUM_SRC-1:0] intr_ena
);

    logic [NUM_SRC-1:0] sync_s;
    logic [NUM_SRC-1:0] filt_s;
    logic [NUM_SRC-1:0] filt_d_r;
    logic [NUM_SRC-1:0] ena_r;
    logic [NUM_SRC-1:0] mode_r;
    logic [NUM_SRC-1:0] pend_r;
    logic [NUM_SRC-1:0] pulse_r;
    logic [7:0]         rdata_r;

    logic               wr_s;
    logic               rd_s;
    logic [NUM_SRC-1:0] rise_s;
    logic [NUM_SRC-1:0] ena_nxt_s;
    logic [NUM_SRC-1:0] mode_nxt_s;
    logic [NUM_SRC-1:0] mode_chg_s;
    logic [NUM_SRC-1:0] pend_clr_s;
    logic [NUM_SRC-1:0] pend_nxt_s;
    logic [NUM_SRC-1:0] pulse_nxt_s;
    logic [7:0]         rdata_nxt_s;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        intr_filt #(
            .FILT_LEN (FILT_LEN)
        ) u_filt (
            .clock    (clock),
            .reset    (reset),
            .src      (src_in[i]),
            .sync_lvl (sync_s[i]),
            .filt_lvl (filt_s[i])
        );
    end

    // Register write decode, pending update and edge-pulse generation.
    always_comb begin
        wr_s       = bus.io_sel & bus.io_wr;
        rd_s       = bus.io_sel & bus.io_rd;
        rise_s     = rise_det(filt_s, filt_d_r);
        ena_nxt_s  = ena_r;
        mode_nxt_s = mode_r;
        pend_clr_s = {NUM_SRC{1'b0}};
        if (wr_s) begin
            case (reg_addr_e'(bus.io_addr))
                REG_ENA:  ena_nxt_s  = bus.io_wdata[NUM_SRC-1:0];
                REG_MODE: mode_nxt_s = bus.io_wdata[NUM_SRC-1:0];
                REG_PEND: pend_clr_s = bus.io_wdata[NUM_SRC-1:0];
                REG_RAW:  pend_clr_s = {NUM_SRC{1'b0}};
                default:  pend_clr_s = {NUM_SRC{1'b0}};
            endcase
        end else begin
            pend_clr_s = {NUM_SRC{1'b0}};
        end
        // A mode flip discards state that was qualified under the old mode.
        mode_chg_s  = mode_nxt_s ^ mode_r;
        pend_nxt_s  = ((pend_r & ~pend_clr_s) | rise_s) & ~mode_chg_s;
        pulse_nxt_s = rise_s & mode_r & ~mode_chg_s;
    end

    // Read mux; RAW packs synchronized levels above filtered levels.
    always_comb begin
        rdata_nxt_s = rdata_r;
        if (rd_s) begin
            case (reg_addr_e'(bus.io_addr))
                REG_ENA:  rdata_nxt_s = {4'd0, ena_r};
                REG_MODE: rdata_nxt_s = {4'd0, mode_r};
                REG_PEND: rdata_nxt_s = {4'd0, pend_r};
                REG_RAW:  rdata_nxt_s = {sync_s, filt_s};
                default:  rdata_nxt_s = 8'h00;
            endcase
        end else begin
            rdata_nxt_s = rdata_r;
        end
    end

    // Register file, edge history and read data.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ena_r    <= {NUM_SRC{1'b0}};
            mode_r   <= {NUM_SRC{1'b0}};
            pend_r   <= {NUM_SRC{1'b0}};
            pulse_r  <= {NUM_SRC{1'b0}};
            filt_d_r <= {NUM_SRC{1'b0}};
            rdata_r  <= 8'h00;
        end else begin
            ena_r    <= ena_nxt_s;
            mode_r   <= mode_nxt_s;
            pend_r   <= pend_nxt_s;
            pulse_r  <= pulse_nxt_s;
            filt_d_r <= filt_s;
            rdata_r  <= rdata_nxt_s;
        end
    end

    assign intr_req     = (mode_r & pulse_r) | (~mode_r & filt_s);
    assign intr_ena     = ena_r;
    assign bus.io_rdata = rdata_r;

endmodule

// File: tb/tb_intr_src_ctrl.sv
// Bench for intr_src_ctrl: directed scenarios plus random traffic, all checked
// against a cycle-level behavioural model of the source conditioner.
module tb_intr_src_ctrl;

    localparam int FL = 3;

    logic       clock;
    logic       reset;
    logic [3:0] src_in;
    logic [3:0] intr_req;
    logic [3:0] intr_ena;

    intr_src_ctrl_if bus ();

    intr_src_ctrl #(.FILT_LEN(FL)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .src_in   (src_in),
        .intr_req (intr_req),
        .intr_ena (intr_ena)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: two-sample pipeline, accepted level, run length per source.
    bit [3:0] m_s1, m_s2, m_filt, m_prev, m_ena, m_mode, m_pend, m_pulse;
    bit [7:0] m_rdata;
    int       m_run [4];

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_step();
        bit [3:0] rise, chg, clr, fold, mold;
        if (!reset) begin
            m_s1 = 4'd0; m_s2 = 4'd0; m_filt = 4'd0; m_prev = 4'd0;
            m_ena = 4'd0; m_mode = 4'd0; m_pend = 4'd0; m_pulse = 4'd0;
            m_rdata = 8'h00;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            fold = m_filt;
            mold = m_mode;
            rise = m_filt & ~m_prev;
            if (bus.io_sel && bus.io_rd) begin
                case (bus.io_addr)
                    2'd0:    m_rdata = {4'd0, m_ena};
                    2'd1:    m_rdata = {4'd0, m_mode};
                    2'd2:    m_rdata = {4'd0, m_pend};
                    default: m_rdata = {m_s2, m_filt};
                endcase
            end
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] == m_filt[i]) m_run[i] = 0;
                else begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] >= FL) begin
                        m_filt[i] = ~m_filt[i];
                        m_run[i]  = 0;
                    end
                end
            end
            m_prev = fold;
            m_s2 = m_s1;
            m_s1 = src_in;
            chg = 4'd0;
            clr = 4'd0;
            if (bus.io_sel && bus.io_wr) begin
                case (bus.io_addr)
                    2'd0:    m_ena = bus.io_wdata[3:0];
                    2'd1:    begin chg = bus.io_wdata[3:0] ^ m_mode; m_mode = bus.io_wdata[3:0]; end
                    2'd2:    clr = bus.io_wdata[3:0];
                    default: clr = 4'd0;
                endcase
            end
            m_pend  = ((m_pend & ~clr) | rise) & ~chg;
            m_pulse = rise & mold & ~chg;
        end
    endtask

    task automatic tick();
        bit [3:0] exp_req;
        @(posedge clock);
        model_step();
        #1;
        exp_req = (m_mode & m_pulse) | (~m_mode & m_filt);
        chk("intr_req", {4'd0, intr_req}, {4'd0, exp_req});
        chk("intr_ena", {4'd0, intr_ena}, {4'd0, m_ena});
        chk("io_rdata", bus.io_rdata, m_rdata);
    endtask

    task automatic idle_bus();
        bus.io_sel = 1'b0; bus.io_rd = 1'b0; bus.io_wr = 1'b0;
        bus.io_addr = 2'd0; bus.io_wdata = 8'h00;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        bus.io_sel = 1'b1; bus.io_rd = 1'b1; bus.io_addr = a;
        tick();
        idle_bus();
        d = bus.io_rdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] v);
        bus.io_sel = 1'b1; bus.io_wr = 1'b1; bus.io_addr = a; bus.io_wdata = v;
        tick();
        idle_bus();
    endtask

    initial begin
        logic [7:0] d;
        int         cnt;
        bit         seen_hi;
        reset  = 1'b0;
        src_in = 4'd0;
        idle_bus();
        tick(); tick();
        reset = 1'b1;

        // Reset state of every register and output
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            chk("reset_reg", d, 8'h00);
        end
        chk("reset_ena", {4'd0, intr_ena}, 8'h00);
        chk("reset_req", {4'd0, intr_req}, 8'h00);

        // Level mode: rise and fall latency on source 1
        src_in[1] = 1'b1;
        cnt = 0;
        while (intr_req[1] !== 1'b1 && cnt < 20) begin tick(); cnt++; end
        chk("lvl_rise_lat", 8'(cnt), 8'd5);
        repeat (5) tick();
        src_in[1] = 1'b0;
        cnt = 0;
        while (intr_req[1] !== 1'b0 && cnt < 20) begin tick(); cnt++; end
        chk("lvl_fall_lat", 8'(cnt), 8'd5);
        rd(2'd2, d);
        chk("lvl_pend", d, 8'h02);
        wr(2'd2, 8'h0F);

        // Edge mode: single-cycle pulse, pending, write-1-to-clear
        wr(2'd1, 8'h01);
        src_in[0] = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin tick(); if (intr_req[0]) cnt++; end
        chk("edge_pulse_len", 8'(cnt), 8'd1);
        rd(2'd2, d);
        chk("edge_pend", d, 8'h01);
        wr(2'd2, 8'h01);
        rd(2'd2, d);
        chk("pend_w1c", d, 8'h00);

        // Short pulse on source 2 is rejected but visible on RAW
        src_in[2] = 1'b1;
        seen_hi = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) src_in[2] = 1'b0;
            rd(2'd3, d);
            if (d[6]) seen_hi = 1'b1;
            if (intr_req[2]) cnt++;
        end
        chk("raw_seen_hi", {7'd0, seen_hi}, 8'h01);
        chk("raw_ends_lo", {7'd0, d[6]}, 8'h00);
        chk("short_req", 8'(cnt), 8'd0);
        rd(2'd2, d);
        chk("short_pend", d, 8'h00);

        // Set of PEND[3] coincides with its write-1-to-clear
        wr(2'd1, 8'h08);
        src_in[3] = 1'b1;
        repeat (5) tick();
        wr(2'd2, 8'h08);
        rd(2'd2, d);
        chk("pend_race", d, 8'h08);

        // ENA upper bits ignored; reset during filtering clears everything
        wr(2'd0, 8'hF5);
        chk("ena_out", {4'd0, intr_ena}, 8'h05);
        rd(2'd0, d);
        chk("ena_read", d, 8'h05);
        src_in = 4'b1011;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_req", {4'd0, intr_req}, 8'h00);
        chk("rst_ena", {4'd0, intr_ena}, 8'h00);
        chk("rst_rdata", bus.io_rdata, 8'h00);
        reset = 1'b1;
        repeat (8) tick();
        rd(2'd2, d);
        chk("post_rst_pend", d, 8'h0B);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) src_in[b] = ~src_in[b];
            reset = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.io_sel   = ($urandom_range(0, 7) != 0);
                bus.io_addr  = 2'($urandom_range(0, 3));
                bus.io_rd    = 1'($urandom_range(0, 1));
                bus.io_wr    = ($urandom_range(0, 2) == 0);
                bus.io_wdata = 8'($urandom);
            end else begin
                idle_bus();
            end
            tick();
        end
        idle_bus();
        reset = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
